// File: rtl/ft245_frame_streamer.sv
// Frames multi-channel samples as [HDR, seq, payload...] bytes, buffers them in a byte FIFO and
// drives them out over an FT245 synchronous-FIFO write port; count mode emits a free-running byte ramp.
module ft245_frame_streamer #(
    parameter int          CHANNELS  = 4,
    parameter int          SAMPLE_W  = 16,
    parameter int          DEPTH     = 512,
    parameter logic [7:0]  HDR_BYTE  = 8'hA5,
    parameter int          BLINK_BIT = 20
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [CHANNELS*SAMPLE_W-1:0]  sample_i,
    input  logic                          sample_valid_i,
    output logic                          sample_ready_o,
    input  logic                          mode_i,
    input  logic                          txe_i,
    output logic                          wr_o,
    output logic                          oe_o,
    output logic [7:0]                    adbus_o,
    output logic                          adbus_oe_o,
    output logic [15:0]                   drop_cnt_o,
    output logic [$clog2(DEPTH+1)-1:0]    level_o,
    output logic                          blinker_o
);

    localparam int SW          = CHANNELS * SAMPLE_W;
    localparam int PAY_BYTES   = SW / 8;
    localparam int FRAME_BYTES = 2 + PAY_BYTES;
    localparam int LW          = $clog2(DEPTH + 1);
    localparam int PW          = $clog2(DEPTH);
    localparam int BW          = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, SEQ, PAY} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic [BW-1:0]   idx_q, idx_d;
    logic [7:0]      seq_q, seq_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [15:0]     drop_q, drop_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      data_q;
    logic [BLINK_BIT:0] xfer_q, xfer_d;

    logic            ready;
    logic            accept;
    logic            push;
    logic [7:0]      push_data;
    logic            transfer;
    logic            pop;

    logic [7:0]      mem [DEPTH];

    // Room for a whole frame is reserved at accept, so a frame is never split.
    assign ready  = rstn_i & (state_q == IDLE) & ~mode_i
                  & ((LW'(DEPTH) - level_q) >= LW'(FRAME_BYTES));
    assign accept = sample_valid_i & ready;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = 8'h00;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d   = sample_i;
                    push      = 1'b1;
                    push_data = HDR_BYTE;
                    state_d   = SEQ;
                end else if (mode_i && (level_q != LW'(DEPTH))) begin
                    push      = 1'b1;
                    push_data = cnt_q;
                    cnt_d     = cnt_q + 8'd1;
                end
            end
            SEQ: begin
                push      = 1'b1;
                push_data = seq_q;
                seq_d     = seq_q + 8'd1;
                idx_d     = '0;
                state_d   = PAY;
            end
            PAY: begin
                // Channel 0 sits in the low bits and samples are little-endian, so shifting
                // the whole vector right a byte at a time yields the wire order directly.
                push      = 1'b1;
                push_data = shift_q[7:0];
                shift_d   = shift_q >> 8;
                idx_d     = idx_q + BW'(1);
                if (idx_q == BW'(PAY_BYTES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (sample_valid_i && !ready && !mode_i && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // The output register refills whenever it is empty or being emptied this edge.
    assign transfer = out_valid_q & ~txe_i;
    assign pop      = (~out_valid_q | transfer) & (level_q != '0);

    always_comb begin
        out_valid_d = out_valid_q;
        if (pop) begin
            out_valid_d = 1'b1;
        end else if (transfer) begin
            out_valid_d = 1'b0;
        end
        wptr_d = push ? (wptr_q + PW'(1)) : wptr_q;
        rptr_d = pop  ? (rptr_q + PW'(1)) : rptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        xfer_d = xfer_q + {{BLINK_BIT{1'b0}}, transfer};
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            seq_q       <= 8'h00;
            cnt_q       <= 8'h00;
            drop_q      <= 16'h0000;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            xfer_q      <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            xfer_q      <= xfer_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr_q] <= push_data;
        end
    end

    // Registered RAM read doubles as the ADBUS output register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            data_q <= 8'h00;
        end else if (pop) begin
            data_q <= mem[rptr_q];
        end
    end

    assign sample_ready_o = ready;
    assign wr_o           = ~out_valid_q;
    assign oe_o           = 1'b1;
    assign adbus_o        = data_q;
    assign adbus_oe_o     = out_valid_q;
    assign drop_cnt_o     = drop_q;
    assign level_o        = level_q;
    assign blinker_o      = xfer_q[BLINK_BIT];

endmodule

// File: tb/tb_ft245_frame_streamer.sv
// Directed + randomized bench for ft245_frame_streamer: byte-stream scoreboard, FT245 hold rules,
// FIFO fill/drop accounting, count mode and mid-frame reset.
module tb_ft245_frame_streamer;

    localparam int CH    = 2;
    localparam int SWID  = 16;
    localparam int DEPTH = 64;
    localparam int BB    = 3;
    localparam int PB    = CH * SWID / 8;
    localparam int FB    = 2 + PB;

    logic              clk = 1'b0;
    logic              rstn_i = 1'b0;
    logic [CH*SWID-1:0] sample_i = '0;
    logic              sample_valid_i = 1'b0;
    logic              sample_ready_o;
    logic              mode_i = 1'b0;
    logic              txe_i = 1'b0;
    logic              wr_o;
    logic              oe_o;
    logic [7:0]        adbus_o;
    logic              adbus_oe_o;
    logic [15:0]       drop_cnt_o;
    logic [6:0]        level_o;
    logic              blinker_o;

    ft245_frame_streamer #(
        .CHANNELS(CH), .SAMPLE_W(SWID), .DEPTH(DEPTH), .HDR_BYTE(8'hA5), .BLINK_BIT(BB)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .sample_ready_o(sample_ready_o), .mode_i(mode_i), .txe_i(txe_i), .wr_o(wr_o),
        .oe_o(oe_o), .adbus_o(adbus_o), .adbus_oe_o(adbus_oe_o), .drop_cnt_o(drop_cnt_o),
        .level_o(level_o), .blinker_o(blinker_o)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  seq_m = 8'h00;
    logic [7:0]  cnt_m = 8'h00;
    logic [31:0] xfer_m = 0;
    bit          mon_en = 1'b0;
    bit          txe_rand = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] s);
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq_m);
        seq_m = seq_m + 8'd1;
        for (int k = 0; k < PB; k++) exp_q.push_back(s[k*8 +: 8]);
    endtask

    // Receiver: every byte taken from ADBUS must be the next scoreboard byte; WR#/data hold under TXE#=1.
    initial begin
        bit         hold_pend = 1'b0;
        logic [7:0] hold_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                hold_pend = 1'b0;
                xfer_m    = 0;
            end else begin
                check("blinker", blinker_o, xfer_m[BB]);
                check("level_bound", level_o <= DEPTH, 1);
                check("oe_tied", oe_o, 1);
                if (hold_pend) begin
                    check("hold_wr", wr_o, 0);
                    check("hold_data", adbus_o, hold_byte);
                end
                if (!wr_o && !txe_i) begin
                    check("stream_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("stream_byte", adbus_o, exp_q.pop_front());
                    xfer_m = xfer_m + 1;
                end
                hold_pend = !wr_o && txe_i;
                hold_byte = adbus_o;
            end
        end
    end

    task automatic do_reset();
        rstn_i = 1'b0; mon_en = 1'b0; sample_valid_i = 1'b0; mode_i = 1'b0; txe_rand = 1'b0;
        exp_q.delete(); seq_m = 8'h00; cnt_m = 8'h00;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_ready", sample_ready_o, 0);
        check("rst_wr", wr_o, 1);
        check("rst_oe", oe_o, 1);
        check("rst_adbus", adbus_o, 0);
        check("rst_adbus_oe", adbus_oe_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        check("rst_level", level_o, 0);
        check("rst_blinker", blinker_o, 0);
        @(posedge clk); #1;
        rstn_i = 1'b1; mon_en = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] s);
        bit got = 1'b0;
        sample_i = s; sample_valid_i = 1'b1;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            got = sample_ready_o;
            @(posedge clk); #1;
            if (txe_rand) txe_i = 1'($urandom_range(0, 1));
        end
        if (got) push_frame(s);
        sample_valid_i = 1'b0;
        check("accept_timeout", got, 1);
    endtask

    task automatic drain();
        txe_rand = 1'b0; txe_i = 1'b0;
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("drain_left", exp_q.size(), 0);
        check("drain_wr", wr_o, 1);
        check("drain_level", level_o, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] t1 = 32'h5678_1234;
        logic [7:0]  t1_bytes[FB] = '{8'hA5, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
        int          nf, lvl, ccount;

        // 1: single known frame, latency and byte order
        txe_i = 1'b0;
        do_reset();
        sample_i = t1; sample_valid_i = 1'b1;
        @(negedge clk);
        check("t1_ready", sample_ready_o, 1);
        @(posedge clk); #1;
        sample_valid_i = 1'b0;
        push_frame(t1);
        @(negedge clk);
        check("t1_wr_1edge", wr_o, 1);
        for (int k = 0; k < FB; k++) begin
            @(negedge clk);
            check("t1_wr_low", wr_o, 0);
            check("t1_byte", adbus_o, t1_bytes[k]);
        end
        @(posedge clk); #1;
        drain();
        send_frame($urandom);
        @(negedge clk);
        @(negedge clk);
        check("t1_hdr2", adbus_o, 8'hA5);
        @(negedge clk);
        check("t1_seq2", adbus_o, 8'h01);
        check("t1_seq2_wr", wr_o, 0);
        @(posedge clk); #1;
        drain();

        // 2: random TXE# toggling over enough frames for seq to wrap
        txe_rand = 1'b1;
        for (int f = 0; f < 260; f++) send_frame($urandom);
        drain();

        // 4a: count mode with TXE# held high fills the FIFO completely; samples are not drops
        do_reset();
        txe_i = 1'b1; mode_i = 1'b1; sample_valid_i = 1'b1; sample_i = $urandom;
        repeat (DEPTH + 20) begin @(posedge clk); #1; end
        @(negedge clk);
        check("t4_level_full", level_o, DEPTH);
        check("t4_wr", wr_o, 0);
        check("t4_first", adbus_o, 8'h00);
        check("t4_nodrop", drop_cnt_o, 0);
        check("t4_noready", sample_ready_o, 0);
        for (int k = 0; k <= DEPTH; k++) begin
            exp_q.push_back(cnt_m);
            cnt_m = cnt_m + 8'd1;
        end
        @(posedge clk); #1;
        mode_i = 1'b0; sample_valid_i = 1'b0;
        drain();

        // 4b: mode raised during PAY; frame finishes, then ramp continues through FF->00
        send_frame($urandom);
        @(posedge clk); #1;
        mode_i = 1'b1;
        repeat (PB) @(posedge clk);
        #1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            exp_q.push_back(cnt_m);
            cnt_m = cnt_m + 8'd1;
        end
        mode_i = 1'b0;
        drain();

        // 3: TXE# stalled, valid every cycle -> whole frames up to capacity, rest are drops
        do_reset();
        nf = 0; lvl = 0;
        while (DEPTH - lvl >= FB) begin
            nf++;
            lvl = nf * FB - 1;
        end
        ccount = 120;
        txe_i = 1'b1; sample_valid_i = 1'b1;
        for (int i = 0; i < ccount; i++) begin
            logic [31:0] s;
            bit          rm;
            s = $urandom;
            sample_i = s;
            rm = (i < nf * FB) && (i % FB == 0);
            @(negedge clk);
            check("t3_ready", sample_ready_o, rm);
            if (rm) push_frame(s);
            @(posedge clk); #1;
        end
        sample_valid_i = 1'b0;
        @(negedge clk);
        check("t3_drops", drop_cnt_o, ccount - nf);
        check("t3_level", level_o, nf * FB - 1);
        check("t3_total", nf * FB, (DEPTH / FB) * FB);
        check("t3_wr", wr_o, 0);
        check("t3_head", adbus_o, 8'hA5);
        @(posedge clk); #1;
        drain();

        // 5: reset for one edge mid-frame with the FIFO about half full
        do_reset();
        txe_i = 1'b1;
        repeat (5) send_frame($urandom);
        send_frame($urandom);
        @(posedge clk); #1;
        rstn_i = 1'b0; mon_en = 1'b0;
        @(posedge clk); #1;
        rstn_i = 1'b1;
        @(negedge clk);
        check("t5_wr", wr_o, 1);
        check("t5_level", level_o, 0);
        check("t5_drop", drop_cnt_o, 0);
        check("t5_adbus_oe", adbus_oe_o, 0);
        check("t5_blinker", blinker_o, 0);
        exp_q.delete(); seq_m = 8'h00;
        @(posedge clk); #1;
        mon_en = 1'b1; txe_i = 1'b0;
        send_frame(32'hCAFE_F00D);
        @(negedge clk);
        @(negedge clk);
        check("t5_hdr", adbus_o, 8'hA5);
        @(negedge clk);
        check("t5_seq", adbus_o, 8'h00);
        @(posedge clk); #1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
